oven_controller_param: RTL and testbench

Parametrised successor to the microwave controller FSM. Generalised timer width, a configurable tick rate (clock cycles per cooking second), multi-level PWM heater power, and a PAUSE state with resume. Drives the four-letter 7-segment state banner and a binary remaining-time bus. Top-level control block between the board switches/buttons and the display decoders.

---
 rtl/oven_controller_param.sv | 208 ++++++++++++++++++++
 tb/tb_oven_controller_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/oven_controller_param.sv
// -----------------------------------------------------------------------------
// oven_controller_param
//
// Control FSM for a microwave oven. It sits between the board switches and
// buttons and the display decoders. The states are IDLE, COOK, PAUSE and DONE.
// The magnetron is driven by a multi-level PWM. A four-letter 7-segment banner
// shows the state, and a binary bus shows the seconds remaining.
//
// Parameters:
//   TIMER_W       width of timer, the remaining-time counter and time_display
//   TICKS_PER_SEC clock cycles per one-second decrement (>= 1)
//   POWER_W       width of power; the PWM period is 2**POWER_W cycles
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous reset, active-high
//   power           heater level (0 = lowest, all-ones = always on)
//   timer           requested cook time in seconds
//   door_status     1 = door closed, 0 = door open
//   start_button    start/resume request, level-sampled
//   cancel_button   abort request, level-sampled
//   heater_on       magnetron enable (PWM, COOK only)
//   done_pulse      one-cycle pulse in the first DONE cycle
//   state_display1  leftmost letter; bits {g,f,e,d,c,b,a}, active-low
//   state_display2  second letter
//   state_display3  third letter
//   state_display4  rightmost letter
//   time_display    IDLE: timer input; COOK/PAUSE: remaining; DONE: 0
//
// Optional feature (macro OVEN_ADD30_EN): each rising edge of start_button
// during COOK adds 30 s to remaining. The sum saturates at all-ones. Without
// the macro, start_button has no effect in COOK.
// -----------------------------------------------------------------------------
module oven_controller_param #(
  parameter int TIMER_W       = 7,
  parameter int TICKS_PER_SEC = 1,
  parameter int POWER_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [POWER_W-1:0] power,
  input  logic [TIMER_W-1:0] timer,
  input  logic               door_status,
  input  logic               start_button,
  input  logic               cancel_button,
  output logic               heater_on,
  output logic               done_pulse,
  output logic [6:0]         state_display1,
  output logic [6:0]         state_display2,
  output logic [6:0]         state_display3,
  output logic [6:0]         state_display4,
  output logic [TIMER_W-1:0] time_display
);

  // A 1-cycle tick still needs a 1-bit counter so that the widths stay legal.
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TIMER_W-1:0] TIME_MAX  = '1;
  localparam logic [TIMER_W-1:0] TIME_ONE  = TIMER_W'(1);

  // Segment letters: each pattern lists the lit segments, then is inverted
  // because the display is active-low. Bit order is {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_I = ~7'b0110000;
  localparam logic [6:0] SEG_D = ~7'b1011110;
  localparam logic [6:0] SEG_L = ~7'b0111000;
  localparam logic [6:0] SEG_E = ~7'b1111001;
  localparam logic [6:0] SEG_P = ~7'b1110011;
  localparam logic [6:0] SEG_R = ~7'b1010000;
  localparam logic [6:0] SEG_O = ~7'b0111111;
  localparam logic [6:0] SEG_C = ~7'b0111001;
  localparam logic [6:0] SEG_N = ~7'b1010100;
  localparam logic [6:0] SEG_A = ~7'b1110111;
  localparam logic [6:0] SEG_U = ~7'b0111110;
  localparam logic [6:0] SEG_S = ~7'b1101101;

  typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_t;

  state_t             state_reg;
  logic [TIMER_W-1:0] remaining_reg;
  logic [TICK_W-1:0]  tick_cnt_reg;
  logic [POWER_W-1:0] pwm_cnt_reg;
  logic               done_pulse_reg;

  // One-second bookkeeping. The decrement is guarded so remaining never wraps.
  logic               tick_wrap;
  logic [TIMER_W-1:0] remaining_dec;
  logic [TIMER_W-1:0] cook_remaining_next;
  logic               cook_finish;

  assign tick_wrap     = (tick_cnt_reg == TICK_LAST);
  assign remaining_dec = (tick_wrap && remaining_reg != '0) ? remaining_reg - 1'b1
                                                            : remaining_reg;

`ifdef OVEN_ADD30_EN
  logic               start_prev_reg;
  logic               add30_req;
  logic [TIMER_W+5:0] add30_sum;   // 6 extra bits hold +30 for any TIMER_W
  logic [TIMER_W-1:0] remaining_add30;

  assign add30_req       = start_button & ~start_prev_reg;
  assign add30_sum       = {6'd0, remaining_dec} + (TIMER_W + 6)'(30);
  assign remaining_add30 = (add30_sum > {6'd0, TIME_MAX}) ? TIME_MAX
                                                          : add30_sum[TIMER_W-1:0];
  // An extension in the same cycle as the final tick keeps the oven cooking.
  assign cook_remaining_next = add30_req ? remaining_add30 : remaining_dec;
  assign cook_finish         = tick_wrap && (remaining_reg == TIME_ONE) && !add30_req;
`else
  assign cook_remaining_next = remaining_dec;
  assign cook_finish         = tick_wrap && (remaining_reg == TIME_ONE);
`endif

  // Each state tests its inputs in the order cancel, door, start, tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      remaining_reg  <= '0;
      tick_cnt_reg   <= '0;
      pwm_cnt_reg    <= '0;
      done_pulse_reg <= 1'b0;
    end else begin
      done_pulse_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (!cancel_button && door_status && start_button && timer != '0) begin
            state_reg     <= S_COOK;
            remaining_reg <= timer;
            tick_cnt_reg  <= '0;
            pwm_cnt_reg   <= '0;
          end
        end
        S_COOK: begin
          if (cancel_button) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
          end else if (!door_status) begin
            state_reg <= S_PAUSE;          // counters freeze where they are
          end else begin
            pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
            tick_cnt_reg  <= tick_wrap ? '0 : tick_cnt_reg + 1'b1;
            remaining_reg <= cook_remaining_next;
            if (cook_finish) begin
              state_reg      <= S_DONE;
              done_pulse_reg <= 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (cancel_button) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
          end else if (door_status && start_button) begin
            state_reg <= S_COOK;
          end
        end
        S_DONE: begin
          if (cancel_button || !door_status) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef OVEN_ADD30_EN
  always_ff @(posedge clk) begin
    if (rst) start_prev_reg <= 1'b0;
    else     start_prev_reg <= start_button;
  end
`endif

  assign done_pulse = done_pulse_reg;
  // The power input is sampled live, so a level change takes effect at once.
  assign heater_on  = (state_reg == S_COOK) && (pwm_cnt_reg <= power);

  always_comb begin
    state_display1 = SEG_I;
    state_display2 = SEG_D;
    state_display3 = SEG_L;
    state_display4 = SEG_E;
    time_display   = timer;
    case (state_reg)
      S_COOK: begin
        state_display1 = SEG_P;
        state_display2 = SEG_R;
        state_display3 = SEG_O;
        state_display4 = SEG_C;
        time_display   = remaining_reg;
      end
      S_PAUSE: begin
        state_display1 = SEG_P;
        state_display2 = SEG_A;
        state_display3 = SEG_U;
        state_display4 = SEG_S;
        time_display   = remaining_reg;
      end
      S_DONE: begin
        state_display1 = SEG_D;
        state_display2 = SEG_O;
        state_display3 = SEG_N;
        state_display4 = SEG_E;
        time_display   = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oven_controller_param.sv
// -----------------------------------------------------------------------------
// Directed testbench for oven_controller_param.
// Two instances share the same stimulus: dut_a has TICKS_PER_SEC=1 and
// dut_b has TICKS_PER_SEC=4. Each scenario task resets both instances and
// then checks the instance that matters for that scenario. Inputs change on
// the falling edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_oven_controller_param;

  localparam logic [27:0] BAN_IDLE  = {7'h4F, 7'h21, 7'h47, 7'h06};
  localparam logic [27:0] BAN_COOK  = {7'h0C, 7'h2F, 7'h40, 7'h46};
  localparam logic [27:0] BAN_PAUSE = {7'h0C, 7'h08, 7'h41, 7'h12};
  localparam logic [27:0] BAN_DONE  = {7'h21, 7'h40, 7'h2B, 7'h06};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] power = 2'd3;
  logic [6:0] timer = 7'd0;
  logic       door_status = 1'b0;
  logic       start_button = 1'b0;
  logic       cancel_button = 1'b0;

  logic       a_heater, a_done, b_heater, b_done;
  logic [6:0] a_s1, a_s2, a_s3, a_s4, b_s1, b_s2, b_s3, b_s4;
  logic [6:0] a_time, b_time;
  logic [27:0] a_ban, b_ban;

  int checks = 0;
  int errors = 0;

  assign a_ban = {a_s1, a_s2, a_s3, a_s4};
  assign b_ban = {b_s1, b_s2, b_s3, b_s4};

  always #5 clk = ~clk;

  oven_controller_param #(.TIMER_W(7), .TICKS_PER_SEC(1), .POWER_W(2)) dut_a (
    .clk(clk), .rst(rst), .power(power), .timer(timer),
    .door_status(door_status), .start_button(start_button),
    .cancel_button(cancel_button), .heater_on(a_heater), .done_pulse(a_done),
    .state_display1(a_s1), .state_display2(a_s2), .state_display3(a_s3),
    .state_display4(a_s4), .time_display(a_time)
  );

  oven_controller_param #(.TIMER_W(7), .TICKS_PER_SEC(4), .POWER_W(2)) dut_b (
    .clk(clk), .rst(rst), .power(power), .timer(timer),
    .door_status(door_status), .start_button(start_button),
    .cancel_button(cancel_button), .heater_on(b_heater), .done_pulse(b_done),
    .state_display1(b_s1), .state_display2(b_s2), .state_display3(b_s3),
    .state_display4(b_s4), .time_display(b_time)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start_button  = 1'b0;
    cancel_button = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    timer = 7'd60; door_status = 1'b0; power = 2'd3;
    do_reset();
    checks++; if (a_ban !== BAN_IDLE) begin errors++; $display("FAIL reset_banner: got %h expected %h", a_ban, BAN_IDLE); end
    checks++; if (a_heater !== 1'b0) begin errors++; $display("FAIL reset_heater: got %b expected 0", a_heater); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
    checks++; if (a_time !== 7'd60) begin errors++; $display("FAIL reset_time: got %0d expected 60", a_time); end
    start_button = 1'b1; step(); start_button = 1'b0; step();
    checks++; if (a_ban !== BAN_IDLE) begin errors++; $display("FAIL door_open_start_banner: got %h expected %h", a_ban, BAN_IDLE); end
    checks++; if (a_heater !== 1'b0) begin errors++; $display("FAIL door_open_start_heater: got %b expected 0", a_heater); end
    checks++; if (a_time !== 7'd60) begin errors++; $display("FAIL door_open_start_time: got %0d expected 60", a_time); end
    door_status = 1'b1; timer = 7'd0; start_button = 1'b1; step(); start_button = 1'b0;
    checks++; if (a_ban !== BAN_IDLE) begin errors++; $display("FAIL zero_timer_start: got %h expected %h", a_ban, BAN_IDLE); end
    $display("test_reset done");
  endtask

  task automatic test_cook_tps1();
    do_reset();
    door_status = 1'b1; timer = 7'd5; power = 2'd3;
    start_button = 1'b1; step(); start_button = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_ban !== BAN_COOK) begin errors++; $display("FAIL cook1_banner[%0d]: got %h expected %h", i, a_ban, BAN_COOK); end
      checks++; if (a_time !== 7'(5 - i)) begin errors++; $display("FAIL cook1_time[%0d]: got %0d expected %0d", i, a_time, 5 - i); end
      checks++; if (a_heater !== 1'b1) begin errors++; $display("FAIL cook1_heater[%0d]: got %b expected 1", i, a_heater); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL cook1_done_early[%0d]: got %b expected 0", i, a_done); end
      step();
    end
    checks++; if (a_ban !== BAN_DONE) begin errors++; $display("FAIL done_banner: got %h expected %h", a_ban, BAN_DONE); end
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL done_pulse_first: got %b expected 1", a_done); end
    checks++; if (a_time !== 7'd0) begin errors++; $display("FAIL done_time: got %0d expected 0", a_time); end
    checks++; if (a_heater !== 1'b0) begin errors++; $display("FAIL done_heater: got %b expected 0", a_heater); end
    start_button = 1'b1; step(); start_button = 1'b0;
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL done_pulse_second: got %b expected 0", a_done); end
    checks++; if (a_ban !== BAN_DONE) begin errors++; $display("FAIL done_ignores_start: got %h expected %h", a_ban, BAN_DONE); end
    door_status = 1'b0; step();
    checks++; if (a_ban !== BAN_IDLE) begin errors++; $display("FAIL done_door_idle: got %h expected %h", a_ban, BAN_IDLE); end
    $display("test_cook_tps1 done");
  endtask

  task automatic test_pause_resume();
    do_reset();
    door_status = 1'b1; timer = 7'd10; power = 2'd3;
    start_button = 1'b1; step(); start_button = 1'b0;
    repeat (12) step();
    checks++; if (b_time !== 7'd7) begin errors++; $display("FAIL pr_time_12: got %0d expected 7", b_time); end
    door_status = 1'b0; step();
    checks++; if (b_ban !== BAN_PAUSE) begin errors++; $display("FAIL pause_banner: got %h expected %h", b_ban, BAN_PAUSE); end
    checks++; if (b_heater !== 1'b0) begin errors++; $display("FAIL pause_heater: got %b expected 0", b_heater); end
    checks++; if (b_time !== 7'd7) begin errors++; $display("FAIL pause_time: got %0d expected 7", b_time); end
    door_status = 1'b1; step(); step();
    checks++; if (b_ban !== BAN_PAUSE) begin errors++; $display("FAIL door_close_no_resume: got %h expected %h", b_ban, BAN_PAUSE); end
    checks++; if (b_time !== 7'd7) begin errors++; $display("FAIL pause_frozen_time: got %0d expected 7", b_time); end
    start_button = 1'b1; step(); start_button = 1'b0;
    checks++; if (b_ban !== BAN_COOK) begin errors++; $display("FAIL resume_banner: got %h expected %h", b_ban, BAN_COOK); end
    repeat (27) step();
    checks++; if (b_ban !== BAN_COOK) begin errors++; $display("FAIL resume_27_banner: got %h expected %h", b_ban, BAN_COOK); end
    checks++; if (b_time !== 7'd1) begin errors++; $display("FAIL resume_27_time: got %0d expected 1", b_time); end
    step();
    checks++; if (b_ban !== BAN_DONE) begin errors++; $display("FAIL resume_28_done: got %h expected %h", b_ban, BAN_DONE); end
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL resume_done_pulse: got %b expected 1", b_done); end
    $display("test_pause_resume done");
  endtask

  task automatic test_pwm();
    logic [0:7] pat1;
    logic [0:7] pat0;
    pat1 = 8'b1100_1100;
    pat0 = 8'b1000_1000;
    do_reset();
    door_status = 1'b1; timer = 7'd100; power = 2'd1;
    start_button = 1'b1; step(); start_button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (b_heater !== pat1[i]) begin errors++; $display("FAIL pwm_p1[%0d]: got %b expected %b", i, b_heater, pat1[i]); end
      step();
    end
    power = 2'd0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (b_heater !== pat0[i]) begin errors++; $display("FAIL pwm_p0[%0d]: got %b expected %b", i, b_heater, pat0[i]); end
      step();
    end
    $display("test_pwm done");
  endtask

  task automatic test_start_cancel();
    do_reset();
    door_status = 1'b1; timer = 7'd20; power = 2'd3;
    start_button = 1'b1; cancel_button = 1'b1; step();
    start_button = 1'b0; cancel_button = 1'b0;
    checks++; if (b_ban !== BAN_IDLE) begin errors++; $display("FAIL start_cancel_banner: got %h expected %h", b_ban, BAN_IDLE); end
    checks++; if (b_heater !== 1'b0) begin errors++; $display("FAIL start_cancel_heater: got %b expected 0", b_heater); end
    checks++; if (b_time !== 7'd20) begin errors++; $display("FAIL start_cancel_time: got %0d expected 20", b_time); end
    $display("test_start_cancel done");
  endtask

  task automatic test_cancel_cook();
    do_reset();
    door_status = 1'b1; timer = 7'd40; power = 2'd3;
    start_button = 1'b1; step(); start_button = 1'b0;
    checks++; if (b_time !== 7'd40) begin errors++; $display("FAIL cancel_pre_time: got %0d expected 40", b_time); end
    cancel_button = 1'b1; step(); cancel_button = 1'b0;
    checks++; if (b_ban !== BAN_IDLE) begin errors++; $display("FAIL cancel_banner: got %h expected %h", b_ban, BAN_IDLE); end
    checks++; if (b_heater !== 1'b0) begin errors++; $display("FAIL cancel_heater: got %b expected 0", b_heater); end
    checks++; if (b_time !== 7'd40) begin errors++; $display("FAIL cancel_time: got %0d expected 40", b_time); end
    timer = 7'd33; step();
    checks++; if (b_time !== 7'd33) begin errors++; $display("FAIL idle_live_timer: got %0d expected 33", b_time); end
    $display("test_cancel_cook done");
  endtask

  task automatic test_add30();
    logic [6:0] exp_a;
    logic [6:0] exp_b;
`ifdef OVEN_ADD30_EN
    exp_a = 7'd127; exp_b = 7'd127;
`else
    exp_a = 7'd110; exp_b = 7'd109;
`endif
    do_reset();
    door_status = 1'b1; timer = 7'd110; power = 2'd3;
    start_button = 1'b1; step(); start_button = 1'b0;
    step();
    start_button = 1'b1; step(); start_button = 1'b0;
    checks++; if (b_time !== exp_a) begin errors++; $display("FAIL add30_first: got %0d expected %0d", b_time, exp_a); end
    step();
    start_button = 1'b1; step(); start_button = 1'b0;
    checks++; if (b_time !== exp_b) begin errors++; $display("FAIL add30_second: got %0d expected %0d", b_time, exp_b); end
    timer = 7'd3; step();
    checks++; if (b_time !== exp_b) begin errors++; $display("FAIL cook_ignores_timer: got %0d expected %0d", b_time, exp_b); end
    $display("test_add30 done");
  endtask

  task automatic test_reset_mid_cook();
    do_reset();
    door_status = 1'b1; timer = 7'd50; power = 2'd3;
    start_button = 1'b1; step(); start_button = 1'b0;
    step();
    checks++; if (b_heater !== 1'b1) begin errors++; $display("FAIL midcook_heater_on: got %b expected 1", b_heater); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (b_ban !== BAN_IDLE) begin errors++; $display("FAIL midcook_reset_banner: got %h expected %h", b_ban, BAN_IDLE); end
    checks++; if (b_heater !== 1'b0) begin errors++; $display("FAIL midcook_reset_heater: got %b expected 0", b_heater); end
    checks++; if (b_time !== 7'd50) begin errors++; $display("FAIL midcook_reset_time: got %0d expected 50", b_time); end
    $display("test_reset_mid_cook done");
  endtask

  initial begin
    test_reset();
    test_cook_tps1();
    test_pause_resume();
    test_pwm();
    test_start_cancel();
    test_cancel_cook();
    test_add30();
    test_reset_mid_cook();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
